// File: rtl/alu_arbiter_pkg.sv
// Shared constants for the two-requester ALU arbiter:
// fcodes, FSM encoding and {s,z,c,v} flag bit positions.
package alu_arbiter_pkg;

  localparam int FCW = 4;

  localparam logic [FCW-1:0] F_ADD = 4'h0;
  localparam logic [FCW-1:0] F_SUB = 4'h1;
  localparam logic [FCW-1:0] F_AND = 4'h2;
  localparam logic [FCW-1:0] F_OR  = 4'h3;
  localparam logic [FCW-1:0] F_XOR = 4'h4;
  localparam logic [FCW-1:0] F_CMP = 4'h5;
  localparam logic [FCW-1:0] F_MOV = 4'h8;

  localparam int S = 3;
  localparam int Z = 2;
  localparam int C = 1;
  localparam int V = 0;

  // Flags reported for an illegal fcode: only z set.
  localparam logic [3:0] FL_ILL = 4'(1 << Z);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic fcode_legal(
    input logic [FCW-1:0] f
  );
    return (f <= F_CMP) || (f == F_MOV);
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester and ALU-side signal bundle of the arbiter.
// slave: the arbiter; master: requesters plus the shared ALU.
interface alu_arbiter_if #(
  parameter int W  = 16,
  parameter int FW = 4
);

  logic          req0;
  logic          req1;
  logic [FW-1:0] fcode0;
  logic [FW-1:0] fcode1;
  logic [W-1:0]  a0;
  logic [W-1:0]  b0;
  logic [W-1:0]  a1;
  logic [W-1:0]  b1;
  logic          done0;
  logic          done1;
  logic [W-1:0]  result;
  logic [3:0]    flags0;
  logic [3:0]    flags1;
  logic          err;
  logic          busy;
  logic [W-1:0]  alu_a;
  logic [W-1:0]  alu_b;
  logic [FW-1:0] alu_fcode;
  logic [W-1:0]  alu_result;
  logic [3:0]    alu_code;

  modport slave (
    input  req0, req1,
    input  fcode0, fcode1,
    input  a0, b0, a1, b1,
    input  alu_result, alu_code,
    output done0, done1,
    output result,
    output flags0, flags1,
    output err, busy,
    output alu_a, alu_b, alu_fcode
  );

  modport master (
    output req0, req1,
    output fcode0, fcode1,
    output a0, b0, a1, b1,
    output alu_result, alu_code,
    input  done0, done1,
    input  result,
    input  flags0, flags1,
    input  err, busy,
    input  alu_a, alu_b, alu_fcode
  );

endinterface

// File: rtl/alu_arbiter_rr_pick.sv
// Two-input round-robin picker: gnt selects the requester,
// ptr breaks the tie when both are asking.
module alu_rr_pick (
  input  logic req0,
  input  logic req1,
  input  logic ptr,
  output logic gnt,
  output logic valid
);

  always_comb begin
    gnt = 1'b0;
    unique case (1'b1)
      (req0 && req1):  gnt = ptr;
      (req1 && !req0): gnt = 1'b1;
      default:         gnt = 1'b0;
    endcase
  end

  assign valid = req0 | req1;

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU between two requesters with a
// round-robin grant and per-requester {s,z,c,v} flags.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int W  = 16,
  parameter int FW = FCW
) (
  input logic          clk,
  input logic          rst,
  alu_arbiter_if.slave bus
);

  state_t        state_q, state_d;
  logic          ptr_q, ptr_d;
  logic          own_q, own_d;
  logic          ill_q, ill_d;
  logic          err_q, err_d;
  logic          done0_q, done0_d;
  logic          done1_q, done1_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  res_q, res_d;
  logic [FW-1:0] fc_q, fc_d;
  logic [3:0]    fl0_q, fl0_d;
  logic [3:0]    fl1_q, fl1_d;

  logic          gnt;
  logic          valid;
  logic [FW-1:0] req_fc;
  logic [W-1:0]  req_a;
  logic [W-1:0]  req_b;
  logic [3:0]    fl_new;

  alu_rr_pick u_pick (
    .req0  (bus.req0),
    .req1  (bus.req1),
    .ptr   (ptr_q),
    .gnt   (gnt),
    .valid (valid)
  );

  assign req_fc = gnt ? bus.fcode1 : bus.fcode0;
  assign req_a  = gnt ? bus.a1 : bus.a0;
  assign req_b  = gnt ? bus.b1 : bus.b0;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    ill_d   = ill_q;
    err_d   = err_q;
    a_d     = a_q;
    b_d     = b_q;
    fc_d    = fc_q;
    res_d   = res_q;
    fl0_d   = fl0_q;
    fl1_d   = fl1_q;
    done0_d = 1'b0;
    done1_d = 1'b0;
    fl_new  = ill_q ? FL_ILL : bus.alu_code;
    unique case (state_q)
      IDLE: begin
        if (valid) begin
          own_d   = gnt;
          ill_d   = !fcode_legal(req_fc);
          a_d     = req_a;
          b_d     = req_b;
          if (fcode_legal(req_fc)) fc_d = req_fc;
          state_d = EXEC;
        end
      end
      // Capture on entry to DONE so result/flags are
      // already valid while the done pulse is high.
      EXEC: begin
        res_d   = ill_q ? '0 : bus.alu_result;
        err_d   = err_q | ill_q;
        if (own_q) fl1_d = fl_new;
        else       fl0_d = fl_new;
        done0_d = !own_q;
        done1_d = own_q;
        state_d = DONE;
      end
      DONE: begin
        ptr_d   = !own_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      own_q   <= 1'b0;
      ill_q   <= 1'b0;
      err_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      fc_q    <= '0;
      res_q   <= '0;
      fl0_q   <= '0;
      fl1_q   <= '0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      ill_q   <= ill_d;
      err_q   <= err_d;
      a_q     <= a_d;
      b_q     <= b_d;
      fc_q    <= fc_d;
      res_q   <= res_d;
      fl0_q   <= fl0_d;
      fl1_q   <= fl1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
    end
  end

  assign bus.done0     = done0_q;
  assign bus.done1     = done1_q;
  assign bus.result    = res_q;
  assign bus.flags0    = fl0_q;
  assign bus.flags1    = fl1_q;
  assign bus.err       = err_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;
  assign bus.alu_fcode = fc_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized self-checking bench for alu_arbiter with a
// stand-in ALU and an arithmetic reference model.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   both_hi;
  int   dn1_cnt;

  logic [3:0]  m_fl [2];
  logic [15:0] m_res;
  logic        m_err;
  logic [3:0]  m_fc;
  logic        m_ptr;

  alu_arbiter_if #(.W(16), .FW(4)) bus ();

  alu_arbiter #(.W(16), .FW(4)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU behaviour from plain integer arithmetic.
  function automatic logic [19:0] model_op(
    input logic [3:0]  f,
    input logic [15:0] a,
    input logic [15:0] b
  );
    int ia, ib, sa, sb, r, sr;
    logic c, v;
    logic [15:0] res;
    ia = int'(a);
    ib = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    c = 1'b0;
    v = 1'b0;
    res = '0;
    case (f)
      4'h0: begin
        r = ia + ib;
        sr = sa + sb;
        c = (r > 65535);
        v = (sr > 32767) || (sr < -32768);
        res = r[15:0];
      end
      4'h1, 4'h5: begin
        r = ia - ib;
        sr = sa - sb;
        c = (ia < ib);
        v = (sr > 32767) || (sr < -32768);
        res = r[15:0];
      end
      4'h2: res = a & b;
      4'h3: res = a | b;
      4'h4: res = a ^ b;
      4'h8: res = b;
      default: res = '0;
    endcase
    return {res, res[15], (res == 16'h0), c, v};
  endfunction

  always_comb begin
    {bus.alu_result, bus.alu_code} =
      model_op(bus.alu_fcode, bus.alu_a, bus.alu_b);
  end

  always @(negedge clk) begin
    if (bus.done0 && bus.done1) both_hi++;
    if (bus.done1) dn1_cnt++;
  end

  function automatic bit is_legal(input logic [3:0] f);
    return (f <= 4'h5) || (f == 4'h8);
  endfunction

  task automatic model_reset();
    m_fl[0] = '0;
    m_fl[1] = '0;
    m_res = '0;
    m_err = 1'b0;
    m_fc = '0;
    m_ptr = 1'b0;
  endtask

  task automatic model_step(
    input int who, input logic [3:0] f,
    input logic [15:0] a, input logic [15:0] b
  );
    logic [19:0] o;
    if (is_legal(f)) begin
      o = model_op(f, a, b);
      m_res = o[19:4];
      m_fl[who] = o[3:0];
      m_fc = f;
    end else begin
      m_res = '0;
      m_fl[who] = 4'b0100;
      m_err = 1'b1;
    end
    m_ptr = (who == 0);
  endtask

  task automatic set_req(
    input int who, input logic v, input logic [3:0] f,
    input logic [15:0] a, input logic [15:0] b
  );
    if (who == 0) begin
      bus.req0 = v; bus.fcode0 = f; bus.a0 = a; bus.b0 = b;
    end else begin
      bus.req1 = v; bus.fcode1 = f; bus.a1 = a; bus.b1 = b;
    end
  endtask

  task automatic drop_req(input int who);
    if (who == 0) bus.req0 = 1'b0;
    else bus.req1 = 1'b0;
  endtask

  // Issue one request from an idle start, wait for a done.
  task automatic run_op(
    input int who, input logic [3:0] f,
    input logic [15:0] a, input logic [15:0] b,
    output int lat, output int seen
  );
    @(negedge clk);
    set_req(who, 1'b1, f, a, b);
    lat = -1;
    seen = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.done0 || bus.done1) begin
        lat = i;
        seen = bus.done1 ? 1 : 0;
        break;
      end
    end
    drop_req(who);
    if (lat >= 0) model_step(who, f, a, b);
  endtask

  task automatic chk_done(
    input string nm, input int who, input int lat, input int seen
  );
    checks++;
    if (lat != 2 || seen != who) begin
      failures++;
      $display("FAIL %s done lat=%0d who=%0d exp lat=2 who=%0d",
               nm, lat, seen, who);
    end
  endtask

  task automatic chk_state(input string nm);
    checks++;
    if (bus.result !== m_res || bus.flags0 !== m_fl[0] ||
        bus.flags1 !== m_fl[1] || bus.err !== m_err ||
        bus.alu_fcode !== m_fc) begin
      failures++;
      $display("FAIL %s got res=%h f0=%b f1=%b err=%b fc=%h exp res=%h f0=%b f1=%b err=%b fc=%h",
               nm, bus.result, bus.flags0, bus.flags1, bus.err,
               bus.alu_fcode, m_res, m_fl[0], m_fl[1], m_err, m_fc);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    set_req(0, 1'b0, 4'h0, 16'h0, 16'h0);
    set_req(1, 1'b0, 4'h0, 16'h0, 16'h0);
    model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.result, bus.alu_a, bus.alu_b, bus.alu_fcode} !== '0) begin
      failures++;
      $display("FAIL reset_data got res=%h a=%h b=%h fc=%h exp all 0",
               bus.result, bus.alu_a, bus.alu_b, bus.alu_fcode);
    end
    checks++;
    if ({bus.flags0, bus.flags1, bus.done0, bus.done1,
         bus.err, bus.busy} !== '0) begin
      failures++;
      $display("FAIL reset_ctrl got f0=%b f1=%b d0=%b d1=%b err=%b busy=%b exp 0",
               bus.flags0, bus.flags1, bus.done0, bus.done1,
               bus.err, bus.busy);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    int lat, seen;
    run_op(0, F_ADD, 16'h7FFF, 16'h0001, lat, seen);
    chk_done("add", 0, lat, seen);
    checks++;
    if (bus.result !== 16'h8000 || bus.flags0 !== 4'b1001 ||
        bus.flags1 !== 4'b0000) begin
      failures++;
      $display("FAIL add_vals got res=%h f0=%b f1=%b exp 8000 1001 0000",
               bus.result, bus.flags0, bus.flags1);
    end
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL add_busy got %b exp 1", bus.busy);
    end
    chk_state("add_model");
  endtask

  task automatic test_sub_cmp();
    int lat, seen;
    run_op(1, F_SUB, 16'h0000, 16'h0001, lat, seen);
    chk_done("sub", 1, lat, seen);
    checks++;
    if (bus.result !== 16'hFFFF || bus.flags1 !== 4'b1010 ||
        bus.flags0 !== 4'b1001) begin
      failures++;
      $display("FAIL sub_vals got res=%h f1=%b f0=%b exp ffff 1010 1001",
               bus.result, bus.flags1, bus.flags0);
    end
    run_op(1, F_CMP, 16'h0005, 16'h0005, lat, seen);
    chk_done("cmp", 1, lat, seen);
    checks++;
    if (bus.flags1 !== 4'b0100) begin
      failures++;
      $display("FAIL cmp_flags got %b exp 0100", bus.flags1);
    end
  endtask

  task automatic test_both(input string nm);
    logic [3:0]  f [2];
    logic [15:0] a [2];
    logic [15:0] b [2];
    int          order [2];
    int          got;
    int          first;
    for (int k = 0; k < 2; k++) begin
      f[k] = 4'($urandom_range(0, 5));
      a[k] = 16'($urandom);
      b[k] = 16'($urandom);
    end
    @(negedge clk);
    set_req(0, 1'b1, f[0], a[0], b[0]);
    set_req(1, 1'b1, f[1], a[1], b[1]);
    first = m_ptr ? 1 : 0;
    got = 0;
    order[0] = -1;
    order[1] = -1;
    for (int i = 0; i < 30 && got < 2; i++) begin
      @(negedge clk);
      if (bus.done0 || bus.done1) begin
        order[got] = bus.done1 ? 1 : 0;
        model_step(order[got], f[order[got]],
                   a[order[got]], b[order[got]]);
        drop_req(order[got]);
        chk_state({nm, "_op"});
        got++;
      end
    end
    checks++;
    if (order[0] != first || order[1] != 1 - first) begin
      failures++;
      $display("FAIL %s order got %0d,%0d exp %0d,%0d",
               nm, order[0], order[1], first, 1 - first);
    end
  endtask

  task automatic test_illegal();
    int lat, seen;
    logic [3:0] fc_before;
    fc_before = bus.alu_fcode;
    run_op(0, 4'b0110, 16'h1111, 16'h2222, lat, seen);
    chk_done("illegal", 0, lat, seen);
    checks++;
    if (bus.result !== 16'h0 || bus.flags0 !== 4'b0100 ||
        bus.err !== 1'b1 || bus.alu_fcode !== fc_before) begin
      failures++;
      $display("FAIL illegal_vals got res=%h f0=%b err=%b fc=%h exp 0 0100 1 %h",
               bus.result, bus.flags0, bus.err, bus.alu_fcode, fc_before);
    end
    run_op(1, F_OR, 16'h00F0, 16'h0F00, lat, seen);
    chk_state("illegal_after");
    checks++;
    if (bus.err !== 1'b1) begin
      failures++;
      $display("FAIL err_sticky got %b exp 1", bus.err);
    end
  endtask

  task automatic test_random();
    logic [3:0] legal [7];
    logic [3:0] f;
    int lat, seen, who;
    legal = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h8};
    for (int n = 0; n < 40; n++) begin
      who = int'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0)
        f = 4'($urandom_range(9, 15));
      else
        f = legal[$urandom_range(0, 6)];
      run_op(who, f, 16'($urandom), 16'($urandom), lat, seen);
      chk_done("rand", who, lat, seen);
      chk_state("rand");
    end
  endtask

  task automatic test_reset_mid();
    int lat, seen, d1;
    @(negedge clk);
    set_req(1, 1'b1, F_MOV, 16'h1234, 16'h1234);
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1 || bus.done1 !== 1'b0) begin
      failures++;
      $display("FAIL mid_exec got busy=%b d1=%b exp 1 0",
               bus.busy, bus.done1);
    end
    d1 = dn1_cnt;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.result, bus.alu_a, bus.alu_b, bus.alu_fcode,
         bus.flags0, bus.flags1, bus.done0, bus.done1,
         bus.err, bus.busy} !== '0) begin
      failures++;
      $display("FAIL mid_reset res=%h a=%h b=%h fc=%h f0=%b f1=%b err=%b busy=%b exp 0",
               bus.result, bus.alu_a, bus.alu_b, bus.alu_fcode,
               bus.flags0, bus.flags1, bus.err, bus.busy);
    end
    drop_req(1);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (dn1_cnt != d1) begin
      failures++;
      $display("FAIL mid_nodone got %0d done1 pulses exp 0",
               dn1_cnt - d1);
    end
    run_op(1, F_MOV, 16'h1234, 16'h1234, lat, seen);
    chk_done("mov_after", 1, lat, seen);
    checks++;
    if (bus.result !== 16'h1234) begin
      failures++;
      $display("FAIL mov_result got %h exp 1234", bus.result);
    end
    chk_state("mov_model");
  endtask

  initial begin
    checks = 0;
    failures = 0;
    both_hi = 0;
    dn1_cnt = 0;
    test_reset();
    test_add();
    test_sub_cmp();
    test_both("both_a");
    test_both("both_b");
    test_illegal();
    test_random();
    test_both("both_c");
    test_reset_mid();
    checks++;
    if (both_hi != 0) begin
      failures++;
      $display("FAIL done_excl got %0d overlaps exp 0", both_hi);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
